io_responder: RTL and testbench

- Memory-mapped peripheral responder on the CPU IO bus: decodes IO_addr, accepts writes and returns read data.
- Hosts an 8-digit seven-segment scanner, 24 LEDs, synchronised switches, debounced buttons and an optional prescaled timer.
- Sits between the single-cycle RISC-V core's IO port and the board pins. Reads are combinational so the core sees data in the same cycle.

---
 rtl/io_responder.sv | 205 ++++++++++++++++++++
 tb/tb_io_responder.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// io_responder: memory-mapped IO peripheral (7-seg scanner, LEDs, switches, debounced buttons).
// Define IO_TIMER_EN to include the prescaled timer at offsets 0x20/0x24.
module io_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFFF000,
    parameter int unsigned SCAN_DIV   = 20000,
    parameter int unsigned DEB_CYCLES = 200000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] IO_addr,
    input  logic [31:0] IO_wr_data,
    input  logic        IO_rd_e,
    input  logic        IO_wr_e,
    output logic [31:0] IO_rd_data,
    input  logic [23:0] sw_i,
    input  logic [4:0]  btn_i,
    output logic [23:0] led_o,
    output logic [7:0]  dig_en_o,
    output logic [7:0]  seg_o
);

    localparam logic [31:0] OFF_DIG  = 32'h00;
    localparam logic [31:0] OFF_TVAL = 32'h20;
    localparam logic [31:0] OFF_TDIV = 32'h24;
    localparam logic [31:0] OFF_LED  = 32'h60;
    localparam logic [31:0] OFF_SW   = 32'h70;
    localparam logic [31:0] OFF_BTN  = 32'h78;

    localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_CYCLES - 1);

    function automatic logic [7:0] hex7seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // Address decode: exact full-width match only
    logic w_hit_dig, w_hit_tval, w_hit_tdiv, w_hit_led, w_hit_sw, w_hit_btn;
    logic w_wr_dig, w_wr_led;

    assign w_hit_dig  = (IO_addr == BASE_ADDR + OFF_DIG);
    assign w_hit_tval = (IO_addr == BASE_ADDR + OFF_TVAL);
    assign w_hit_tdiv = (IO_addr == BASE_ADDR + OFF_TDIV);
    assign w_hit_led  = (IO_addr == BASE_ADDR + OFF_LED);
    assign w_hit_sw   = (IO_addr == BASE_ADDR + OFF_SW);
    assign w_hit_btn  = (IO_addr == BASE_ADDR + OFF_BTN);

    assign w_wr_dig = IO_wr_e & w_hit_dig;
    assign w_wr_led = IO_wr_e & w_hit_led;

    logic [31:0] r_dig;
    logic [23:0] r_led;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dig <= '0;
            r_led <= '0;
        end else begin
            if (w_wr_dig) r_dig <= IO_wr_data;
            if (w_wr_led) r_led <= IO_wr_data[23:0];
        end
    end

    assign led_o = r_led;

    logic [23:0] r_sw_s1, r_sw_s2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= sw_i;
            r_sw_s2 <= r_sw_s1;
        end
    end

    logic [4:0]     r_btn_s1, r_btn_s2, r_btn_db;
    logic [DCW-1:0] r_deb_cnt [5];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
        end else begin
            r_btn_s1 <= btn_i;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // Each bit must disagree with its debounced value for DEB_CYCLES straight cycles to flip
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_btn_db <= '0;
            for (int unsigned i = 0; i < 5; i++) r_deb_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                if (r_btn_s2[i] == r_btn_db[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_btn_db[i]  <= r_btn_s2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DCW'(1);
                end
            end
        end
    end

    logic [SCW-1:0] r_scan_cnt;
    logic [2:0]     r_scan_idx;
    logic [7:0]     r_dig_en, r_seg;
    logic [3:0]     w_nibble;

    assign w_nibble = r_dig[{r_scan_idx, 2'b00} +: 4];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_dig_en   <= '1;
            r_seg      <= '1;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_scan_idx <= r_scan_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + SCW'(1);
            end
            r_dig_en <= ~(8'h01 << r_scan_idx);
            r_seg    <= hex7seg(w_nibble);
        end
    end

    assign dig_en_o = r_dig_en;
    assign seg_o    = r_seg;

    logic [31:0] w_tmr_val_rd, w_tmr_div_rd;

`ifdef IO_TIMER_EN
    logic [31:0] r_tmr_val, r_tmr_div, r_tmr_cnt;
    logic        w_wr_tval, w_wr_tdiv, w_tmr_tick;

    assign w_wr_tval  = IO_wr_e & w_hit_tval;
    assign w_wr_tdiv  = IO_wr_e & w_hit_tdiv;
    assign w_tmr_tick = (r_tmr_div != '0) && (r_tmr_cnt == r_tmr_div - 32'd1);

    // Bus writes take priority over the increment and restart the prescale period
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmr_val <= '0;
            r_tmr_div <= '0;
            r_tmr_cnt <= '0;
        end else begin
            if (w_wr_tval)       r_tmr_val <= IO_wr_data;
            else if (w_tmr_tick) r_tmr_val <= r_tmr_val + 32'd1;

            if (w_wr_tdiv) r_tmr_div <= IO_wr_data;

            if (w_wr_tval || w_wr_tdiv || w_tmr_tick || (r_tmr_div == '0)) r_tmr_cnt <= '0;
            else                                                            r_tmr_cnt <= r_tmr_cnt + 32'd1;
        end
    end

    assign w_tmr_val_rd = r_tmr_val;
    assign w_tmr_div_rd = r_tmr_div;
`else
    assign w_tmr_val_rd = '0;
    assign w_tmr_div_rd = '0;
`endif

    logic [31:0] w_rd_mux;

    always_comb begin
        w_rd_mux = '0;
        if (w_hit_dig)       w_rd_mux = r_dig;
        else if (w_hit_tval) w_rd_mux = w_tmr_val_rd;
        else if (w_hit_tdiv) w_rd_mux = w_tmr_div_rd;
        else if (w_hit_led)  w_rd_mux = {8'h00, r_led};
        else if (w_hit_sw)   w_rd_mux = {8'h00, r_sw_s2};
        else if (w_hit_btn)  w_rd_mux = {27'd0, r_btn_db};
        IO_rd_data = IO_rd_e ? w_rd_mux : '0;
    end

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder with short scan/debounce periods.
module tb_io_responder;

    localparam logic [31:0] BASE = 32'hFFFFF000;
    localparam int unsigned SCAN = 4;
    localparam int unsigned DEB  = 8;

    localparam logic [31:0] A_DIG  = BASE + 32'h00;
    localparam logic [31:0] A_TVAL = BASE + 32'h20;
    localparam logic [31:0] A_TDIV = BASE + 32'h24;
    localparam logic [31:0] A_LED  = BASE + 32'h60;
    localparam logic [31:0] A_SW   = BASE + 32'h70;
    localparam logic [31:0] A_BTN  = BASE + 32'h78;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] IO_addr = '0;
    logic [31:0] IO_wr_data = '0;
    logic        IO_rd_e = 1'b0;
    logic        IO_wr_e = 1'b0;
    logic [31:0] IO_rd_data;
    logic [23:0] sw_i = '0;
    logic [4:0]  btn_i = '0;
    logic [23:0] led_o;
    logic [7:0]  dig_en_o;
    logic [7:0]  seg_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    io_responder #(
        .BASE_ADDR (BASE),
        .SCAN_DIV  (SCAN),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .IO_addr   (IO_addr),
        .IO_wr_data(IO_wr_data),
        .IO_rd_e   (IO_rd_e),
        .IO_wr_e   (IO_wr_e),
        .IO_rd_data(IO_rd_data),
        .sw_i      (sw_i),
        .btn_i     (btn_i),
        .led_o     (led_o),
        .dig_en_o  (dig_en_o),
        .seg_o     (seg_o)
    );

    always #5 clk = ~clk;

    // Edges elapsed since reset was last released
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        IO_addr    = addr;
        IO_wr_data = data;
        IO_wr_e    = 1'b1;
        tick();
        IO_wr_e    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        IO_addr = addr;
        IO_rd_e = 1'b1;
        #1;
        data    = IO_rd_data;
        IO_rd_e = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        bus_write(A_DIG, $urandom);
        bus_write(A_LED, $urandom | 32'h1);
        sw_i  = 24'($urandom) | 24'h1;
        btn_i = 5'h1F;
        repeat (DEB + 4) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (led_o !== 24'h0) begin n_fail++; $display("FAIL reset_led_o got %h exp 000000", led_o); end
        n_checks++;
        if (dig_en_o !== 8'hFF) begin n_fail++; $display("FAIL reset_dig_en got %h exp FF", dig_en_o); end
        n_checks++;
        if (seg_o !== 8'hFF) begin n_fail++; $display("FAIL reset_seg got %h exp FF", seg_o); end
        bus_read(A_DIG, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_dig_reg got %h exp 0", rd); end
        bus_read(A_LED, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_led_reg got %h exp 0", rd); end
        bus_read(A_SW, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_sw got %h exp 0", rd); end
        bus_read(A_BTN, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_btn got %h exp 0", rd); end
        tick();
        btn_i = '0;
        sw_i  = '0;
        rst   = 1'b0;
    endtask

    task automatic test_scan();
        logic [31:0] shown, m_dig, nxt;
        int unsigned idx;
        logic [7:0]  exp_en, exp_seg;
        do_reset();
        shown = 32'h0;
        m_dig = 32'h89ABCDEF;
        nxt   = 32'h0;
        bus_write(A_DIG, m_dig);
        for (int s = 0; s < 48; s++) begin
            if (s == 38) begin
                nxt        = $urandom;
                IO_addr    = A_DIG;
                IO_wr_data = nxt;
                IO_wr_e    = 1'b1;
            end
            idx     = ((cyc - 1) / SCAN) % 8;
            exp_en  = ~(8'h01 << idx);
            exp_seg = seg_tab[(shown >> (4 * idx)) & 32'hF];
            n_checks++;
            if (dig_en_o !== exp_en) begin
                n_fail++; $display("FAIL scan_dig_en cyc %0d got %h exp %h", cyc, dig_en_o, exp_en);
            end
            n_checks++;
            if (seg_o !== exp_seg) begin
                n_fail++; $display("FAIL scan_seg cyc %0d got %h exp %h", cyc, seg_o, exp_seg);
            end
            tick();
            IO_wr_e = 1'b0;
            shown   = m_dig;
            if (s == 38) m_dig = nxt;
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (dig_en_o !== 8'hFF || seg_o !== 8'hFF) begin
            n_fail++; $display("FAIL scan_midreset got %h/%h exp FF/FF", dig_en_o, seg_o);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (dig_en_o !== 8'hFE || seg_o !== 8'hC0) begin
            n_fail++; $display("FAIL scan_after_reset got %h/%h exp FE/C0", dig_en_o, seg_o);
        end
    endtask

    task automatic test_led();
        logic [23:0] m_led;
        logic [31:0] data, rd;
        do_reset();
        m_led = '0;
        for (int it = 0; it < 4; it++) begin
            data       = (it == 0) ? 32'hFF123456 : $urandom;
            IO_addr    = A_LED;
            IO_wr_data = data;
            IO_wr_e    = 1'b1;
            IO_rd_e    = 1'b1;
            #1;
            n_checks++;
            if (IO_rd_data !== {8'h00, m_led}) begin
                n_fail++; $display("FAIL led_rw_same_cycle got %h exp %h", IO_rd_data, {8'h00, m_led});
            end
            tick();
            IO_wr_e = 1'b0;
            IO_rd_e = 1'b0;
            m_led   = data[23:0];
            bus_read(A_LED, rd);
            n_checks++;
            if (rd !== {8'h00, m_led}) begin
                n_fail++; $display("FAIL led_read got %h exp %h", rd, {8'h00, m_led});
            end
            n_checks++;
            if (led_o !== m_led) begin
                n_fail++; $display("FAIL led_o got %h exp %h", led_o, m_led);
            end
        end
    endtask

    task automatic test_sw();
        logic [23:0] m_sw, v;
        logic [31:0] rd;
        sw_i = '0;
        tick();
        tick();
        m_sw = '0;
        for (int it = 0; it < 4; it++) begin
            v    = (it == 0) ? 24'hA5A5A5 : 24'($urandom);
            sw_i = v;
            for (int d = 0; d < 3; d++) begin
                bus_read(A_SW, rd);
                n_checks++;
                if (rd !== {8'h00, (d == 2) ? v : m_sw}) begin
                    n_fail++; $display("FAIL sw_sync delay %0d got %h exp %h", d, rd, {8'h00, (d == 2) ? v : m_sw});
                end
                if (d < 2) tick();
            end
            m_sw = v;
        end
        bus_read(BASE + 32'h74, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got %h exp 0", rd); end
        IO_addr = A_SW;
        IO_rd_e = 1'b0;
        #1;
        n_checks++;
        if (IO_rd_data !== 32'h0) begin n_fail++; $display("FAIL rd_e_low got %h exp 0", IO_rd_data); end
    endtask

    task automatic test_btn();
        logic [31:0] rd;
        logic [4:0]  mask, expv;
        int unsigned b, len;
        btn_i = '0;
        do_reset();
        // Glitches shorter than the debounce window never register
        for (int it = 0; it < 3; it++) begin
            b   = $urandom_range(0, 4);
            len = $urandom_range(1, DEB - 1);
            btn_i[b] = 1'b1;
            for (int k = 0; k < int'(len) + 12; k++) begin
                if (k == int'(len)) btn_i = '0;
                tick();
                bus_read(A_BTN, rd);
                n_checks++;
                if (rd !== 32'h0) begin
                    n_fail++; $display("FAIL btn_glitch len %0d got %h exp 0", len, rd);
                end
            end
        end
        // Held level appears after 2 sync cycles plus DEB stable cycles
        mask  = 5'($urandom_range(1, 31));
        btn_i = mask;
        for (int k = 1; k <= 12; k++) begin
            tick();
            expv = (k >= 2 + int'(DEB)) ? mask : 5'h0;
            bus_read(A_BTN, rd);
            n_checks++;
            if (rd !== {27'd0, expv}) begin
                n_fail++; $display("FAIL btn_press k %0d got %h exp %h", k, rd, expv);
            end
        end
        btn_i = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            expv = (k >= 2 + int'(DEB)) ? 5'h0 : mask;
            bus_read(A_BTN, rd);
            n_checks++;
            if (rd !== {27'd0, expv}) begin
                n_fail++; $display("FAIL btn_release k %0d got %h exp %h", k, rd, expv);
            end
        end
        btn_i = mask;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        bus_read(A_BTN, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL btn_midreset got %h exp 0", rd); end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            expv = (k >= 2 + int'(DEB)) ? mask : 5'h0;
            bus_read(A_BTN, rd);
            n_checks++;
            if (rd !== {27'd0, expv}) begin
                n_fail++; $display("FAIL btn_after_reset k %0d got %h exp %h", k, rd, expv);
            end
        end
        btn_i = '0;
    endtask

`ifdef IO_TIMER_EN
    task automatic test_timer();
        logic [31:0] rd, base, expv, div;
        do_reset();
        bus_write(A_TDIV, 32'd3);
        bus_read(A_TDIV, rd);
        n_checks++;
        if (rd !== 32'd3) begin n_fail++; $display("FAIL tmr_div_read got %h exp 3", rd); end
        base = 32'hFFFFFFFE;
        bus_write(A_TVAL, base);
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) tick();
            expv = base + 32'(k / 3);
            bus_read(A_TVAL, rd);
            n_checks++;
            if (rd !== expv) begin n_fail++; $display("FAIL tmr_wrap k %0d got %h exp %h", k, rd, expv); end
        end
        tick();
        bus_write(A_TVAL, 32'd5);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick();
            expv = 32'd5 + 32'(k / 3);
            bus_read(A_TVAL, rd);
            n_checks++;
            if (rd !== expv) begin n_fail++; $display("FAIL tmr_write_wins k %0d got %h exp %h", k, rd, expv); end
        end
        bus_write(A_TDIV, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            bus_read(A_TVAL, rd);
            n_checks++;
            if (rd !== 32'd6) begin n_fail++; $display("FAIL tmr_stopped got %h exp 6", rd); end
        end
        div  = 32'($urandom_range(1, 5));
        base = $urandom;
        bus_write(A_TDIV, div);
        bus_write(A_TVAL, base);
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
            expv = base + 32'(k) / div;
            bus_read(A_TVAL, rd);
            n_checks++;
            if (rd !== expv) begin n_fail++; $display("FAIL tmr_rand div %0d k %0d got %h exp %h", div, k, rd, expv); end
        end
    endtask
`else
    task automatic test_no_timer();
        logic [31:0] rd;
        bus_write(A_TDIV, 32'd7);
        bus_write(A_TVAL, $urandom | 32'h1);
        tick();
        bus_read(A_TVAL, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL no_timer_val got %h exp 0", rd); end
        bus_read(A_TDIV, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL no_timer_div got %h exp 0", rd); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan();
        test_led();
        test_sw();
        test_btn();
`ifdef IO_TIMER_EN
        test_timer();
`else
        test_no_timer();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
